hpi_master_ctrl: RTL

- Parametrised HPI bus master for the CY7C67200 USB host port, replacing the software-bit-banged otg_hpi_* PIO path.
- Accepts single read/write requests over a valid/ready handshake and drives active-low CS/R/W strobes with configurable setup, strobe and hold timing.
- Returns read data with a response pulse.
- Also holds a multi-slot keycode register file, generalising the single 16-bit keycode export to NUM_KEYS 8-bit slots.

---
 rtl/hpi_master_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/hpi_master_ctrl.sv
// HPI bus master for the CY7C67200 host port: valid/ready requests become timed CS/R/W cycles,
// plus a NUM_KEYS-slot keycode register file. Define HPI_RESET_SEQ_EN for a sequenced HPI reset.
module hpi_master_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int NUM_KEYS   = 2,
    parameter int RST_CYC    = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [ADDR_W-1:0]       otg_hpi_address_export,
    output logic                    otg_hpi_cs_export,
    output logic                    otg_hpi_r_export,
    output logic                    otg_hpi_w_export,
    input  logic [DATA_W-1:0]       otg_hpi_data_in_port,
    output logic [DATA_W-1:0]       otg_hpi_data_out_port,
    output logic                    otg_hpi_reset_export,
    input  logic                    hpi_reset_req,
    input  logic                    kc_wr,
    input  logic                    kc_clr,
    input  logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] kc_slot,
    input  logic [7:0]              kc_data,
    output logic [8*NUM_KEYS-1:0]   keycode_export
);

    localparam int KS_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_B   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RST    = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  address_reg;
    logic [DATA_W-1:0]  data_out_reg;
    logic [DATA_W-1:0]  rdata_cap_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic               rsp_valid_reg, rsp_valid_next;
    logic               cs_reg, cs_next;
    logic               r_reg, r_next;
    logic               w_reg, w_next;
    logic               hpi_rst_reg, hpi_rst_next;
    logic               accept;
    logic               rd_sample;
    logic               cnt_zero;

`ifdef HPI_RESET_SEQ_EN
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYC - 1);
    logic rst_pend_reg;

    // A reset request that cannot start yet waits here until the FSM is idle again.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rst_pend_reg <= 1'b0;
        end else if (state_next == RST) begin
            rst_pend_reg <= 1'b0;
        end else if (hpi_reset_req && state_reg != RST) begin
            rst_pend_reg <= 1'b1;
        end
    end

    assign req_ready = reset_reset_n && (state_reg == IDLE) && !rst_pend_reg;
`else
    assign req_ready = reset_reset_n && (state_reg == IDLE);
`endif

    assign cnt_zero = (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                end
`ifdef HPI_RESET_SEQ_EN
                else if (hpi_reset_req || rst_pend_reg) begin
                    state_next = RST;
                    cnt_next   = RST_LD;
                end
`endif
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`ifdef HPI_RESET_SEQ_EN
            RST: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin levels are decoded from the next state so every HPI output comes straight from a flop.
    always_comb begin
        we_next        = accept ? req_we : we_reg;
        cs_next        = !((state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD));
        r_next         = !((state_next == STROBE) && !we_next);
        w_next         = !((state_next == STROBE) && we_next);
        rsp_valid_next = (state_reg == HOLD) && (state_next == IDLE);
        rd_sample      = (state_reg == STROBE) && cnt_zero && !we_reg;
`ifdef HPI_RESET_SEQ_EN
        hpi_rst_next   = (state_next != RST);
`else
        hpi_rst_next   = !hpi_reset_req;
`endif
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            address_reg   <= '0;
            data_out_reg  <= '0;
            rdata_cap_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            cs_reg        <= 1'b1;
            r_reg         <= 1'b1;
            w_reg         <= 1'b1;
            hpi_rst_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            cs_reg        <= cs_next;
            r_reg         <= r_next;
            w_reg         <= w_next;
            hpi_rst_reg   <= hpi_rst_next;
            rsp_valid_reg <= rsp_valid_next;
            if (accept) begin
                address_reg <= req_addr;
                if (req_we) begin
                    data_out_reg <= req_wdata;
                end
            end
            if (rd_sample) begin
                rdata_cap_reg <= otg_hpi_data_in_port;
            end
            // Read data is published together with its completion pulse, not at the sample edge.
            if (rsp_valid_next && !we_reg) begin
                rsp_rdata_reg <= rdata_cap_reg;
            end
        end
    end

    assign otg_hpi_address_export = address_reg;
    assign otg_hpi_data_out_port  = data_out_reg;
    assign otg_hpi_cs_export      = cs_reg;
    assign otg_hpi_r_export       = r_reg;
    assign otg_hpi_w_export       = w_reg;
    assign otg_hpi_reset_export   = hpi_rst_reg;
    assign rsp_valid              = rsp_valid_reg;
    assign rsp_rdata              = rsp_rdata_reg;

    // Slots whose index is never matched (kc_slot >= NUM_KEYS) are simply not written.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_kc
            logic [7:0] kc_reg;
            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n || kc_clr) begin
                    kc_reg <= 8'h00;
                end else if (kc_wr && (kc_slot == KS_W'(gi))) begin
                    kc_reg <= kc_data;
                end
            end
            assign keycode_export[8*gi +: 8] = kc_reg;
        end
    endgenerate

endmodule
